seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 77 +++++++
 tb/tb_seg_scan_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 4-digit BCD scan controller with frame-synchronous load handshake
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  output logic        ready,
  input  logic        enable,
  input  logic        blank_en,
  output logic [3:0]  bcd,
  output logic [3:0]  com,
  output logic        frame_done
);
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      disp;
  logic [15:0]      pend;
  logic             pend_v;
  logic             tick;
  logic             frame;
  logic             accept;
  logic [3:0]       blank_vec;
  logic             show;

  assign tick   = cnt == CNT_W'(SCAN_DIV - 1);
  assign frame  = tick & (idx == 2'd3);
  assign ready  = ~pend_v;
  assign accept = load & ready;
  // Digit i is blanked when it and every more-significant digit are zero; digit 0 always shows
  assign blank_vec = {blank_en & (disp[15:12] == 4'h0),
                      blank_en & (disp[15:8] == 8'h00),
                      blank_en & (disp[15:4] == 12'h000),
                      1'b0};
  assign show = enable & ~blank_vec[idx];

  // Prescaler and digit index free-run, independent of enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      idx <= tick ? idx + 2'd1 : idx;
    end
  end

  // Pending buffer accepts loads; display only changes at a frame boundary so a frame never mixes values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= 16'h0000;
      pend_v <= 1'b0;
      disp   <= 16'h0000;
    end else if (accept) begin
      pend   <= value;
      pend_v <= 1'b1;
    end else if (frame && pend_v) begin
      disp   <= pend;
      pend_v <= 1'b0;
    end
  end

  // Registered digit outputs, one cycle behind idx and display state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd        <= 4'h0;
      com        <= 4'b1111;
      frame_done <= 1'b0;
    end else begin
      bcd        <= disp[{idx, 2'b00} +: 4];
      com        <= show ? ~(4'b0001 << idx) : 4'b1111;
      frame_done <= frame;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed self-checking bench for seg_scan_ctrl with SCAN_DIV=4
module tb_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        ready;
  logic        enable = 1'b1;
  logic        blank_en = 1'b0;
  logic [3:0]  bcd;
  logic [3:0]  com;
  logic        frame_done;
  int total = 0;
  int bad = 0;

  seg_scan_ctrl #(.SCAN_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .ready(ready),
    .enable(enable), .blank_en(blank_en), .bcd(bcd), .com(com), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = frame_done;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL wait_frame: frame_done=%b required 1 within 40 cycles", frame_done);
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({bcd, com, frame_done, ready} !== {4'h0, 4'b1111, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_outputs: bcd=%h com=%b fd=%b ready=%b required 0 1111 0 1", bcd, com, frame_done, ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_scan();
    for (int k = 0; k < 16; k++) begin
      step();
      total++;
      if (com !== ~(4'b0001 << (k / 4)) || bcd !== 4'h0 || frame_done !== (k == 15)) begin
        bad++;
        $display("FAIL scan k=%0d: com=%b bcd=%h fd=%b required com=%b bcd=0 fd=%b",
                 k, com, bcd, frame_done, ~(4'b0001 << (k / 4)), k == 15);
      end
    end
  endtask

  task automatic test_load();
    logic [15:0] exp_v = 16'h1234;
    repeat (5) step();
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL load_ready_before: ready=%b required 1", ready); end
    load = 1'b1; value = 16'h1234;
    step();
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL load_ready_drop: ready=%b required 0", ready); end
    value = 16'h9999;
    step();
    load = 1'b0;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL load_ignored_ready: ready=%b required 0", ready); end
    wait_frame();
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL load_ready_return: ready=%b required 1", ready); end
    for (int k = 0; k < 16; k++) begin
      step();
      total++;
      if (bcd !== exp_v[(k / 4) * 4 +: 4] || com !== ~(4'b0001 << (k / 4))) begin
        bad++;
        $display("FAIL load_frame k=%0d: bcd=%h com=%b required bcd=%h com=%b",
                 k, bcd, com, exp_v[(k / 4) * 4 +: 4], ~(4'b0001 << (k / 4)));
      end
    end
  endtask

  task automatic test_blank();
    logic [3:0] exp_com;
    blank_en = 1'b1; load = 1'b1; value = 16'h0050;
    step();
    load = 1'b0;
    wait_frame();
    for (int k = 0; k < 16; k++) begin
      step();
      exp_com = (k / 4) <= 1 ? ~(4'b0001 << (k / 4)) : 4'b1111;
      total++;
      if (com !== exp_com || bcd !== ((k / 4) == 1 ? 4'h5 : 4'h0)) begin
        bad++;
        $display("FAIL blank_0050 k=%0d: com=%b bcd=%h required com=%b", k, com, bcd, exp_com);
      end
    end
    load = 1'b1; value = 16'h0000;
    step();
    load = 1'b0;
    wait_frame();
    for (int k = 0; k < 16; k++) begin
      step();
      exp_com = k < 4 ? 4'b1110 : 4'b1111;
      total++;
      if (com !== exp_com || bcd !== 4'h0) begin
        bad++;
        $display("FAIL blank_0000 k=%0d: com=%b bcd=%h required com=%b bcd=0", k, com, bcd, exp_com);
      end
    end
    blank_en = 1'b0;
  endtask

  task automatic test_enable();
    wait_frame();
    repeat (5) step();
    enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      total++;
      if (com !== 4'b1111) begin bad++; $display("FAIL disabled k=%0d: com=%b required 1111", k, com); end
    end
    enable = 1'b1;
    step();
    total++;
    if (com !== 4'b0111) begin bad++; $display("FAIL reenable_slot: com=%b required 0111", com); end
    repeat (3) step();
    total++;
    if (frame_done !== 1'b1) begin bad++; $display("FAIL enable_frame_done: fd=%b required 1", frame_done); end
  endtask

  task automatic test_reset_pending();
    repeat (3) step();
    load = 1'b1; value = 16'h5678;
    step();
    load = 1'b0;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL pend_ready: ready=%b required 0", ready); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bcd, com, frame_done, ready} !== {4'h0, 4'b1111, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL midreset_outputs: bcd=%h com=%b fd=%b ready=%b required 0 1111 0 1", bcd, com, frame_done, ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      total++;
      if (com !== ~(4'b0001 << ((k % 16) / 4)) || bcd !== 4'h0 || frame_done !== (k == 15 || k == 31) || ready !== 1'b1) begin
        bad++;
        $display("FAIL post_reset k=%0d: com=%b bcd=%h fd=%b ready=%b required com=%b bcd=0 fd=%b ready=1",
                 k, com, bcd, frame_done, ready, ~(4'b0001 << ((k % 16) / 4)), k == 15 || k == 31);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_blank();
    test_enable();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
